// File: rtl/ioctl_sdram_reader_pkg.sv
// ioctl_pkg: shared types and constants for the data_io upload reader.
package ioctl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SERVE} rd_state_t;
  localparam int IOCTL_ADDR_W = 25;
  function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/ioctl_sdram_reader_if.sv
// ioctl_sdram_reader_if: toggle req/ack SDRAM client port bundle.
interface ioctl_sdram_reader_if #(parameter int AW = 23);
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_q;
  modport master (output port_req, port_a, port_ds, port_we, input port_ack, port_q);
  modport slave  (input port_req, port_a, port_ds, port_we, output port_ack, port_q);
endinterface

// File: rtl/ioctl_sdram_reader_toggle_port_client.sv
// toggle_port_client: issues toggle req/ack accesses, one outstanding at a time, with timeout counter.
module toggle_port_client #(
  parameter int AW          = 23,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          i_issue,
  input  logic          i_abort,
  input  logic [AW-1:0] i_addr,
  input  logic          i_ack,
  output logic          o_req,
  output logic [AW-1:0] o_a,
  output logic          o_done,
  output logic          o_idle,
  output logic          o_tmo
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic          r_pend, r_out;
  logic [AW-1:0] r_na;
  logic [TW-1:0] r_tmo;
  logic          w_free, w_want, w_go;
  // a request raised while an abandoned access is still in flight parks in r_pend
  assign w_free = i_ack == o_req;
  assign w_want = i_issue | r_pend;
  assign w_go   = w_want & w_free & ~i_abort;
  assign o_done = r_out & w_free;
  assign o_idle = w_free & ~r_pend;
  assign o_tmo  = r_tmo == TW'(TIMEOUT_CYC);
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      o_req  <= 1'b0;
      o_a    <= '0;
      r_na   <= '0;
      r_pend <= 1'b0;
      r_out  <= 1'b0;
      r_tmo  <= '0;
    end else begin
      o_req  <= o_req ^ w_go;
      if (i_issue) r_na <= i_addr;
      if (w_go) o_a <= i_issue ? i_addr : r_na;
      r_pend <= w_want & ~w_free & ~i_abort;
      r_out  <= w_go | (r_out & ~w_free & ~i_issue & ~i_abort);
      r_tmo  <= i_issue ? '0 : r_tmo + TW'(r_pend | r_out);
    end
  end
endmodule

// File: rtl/ioctl_sdram_reader.sv
// ioctl_sdram_reader: serves data_io upload byte reads from SDRAM words via a one-word cache.
// Define IOCTL_READ_PREFETCH_EN to prefetch the next word after an odd-byte serve.
module ioctl_sdram_reader import ioctl_pkg::*; #(
  parameter int AW          = 23,
  parameter int BASE_WORD   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_din,
  output logic                    rd_ready,
  output logic                    rd_err,
  ioctl_sdram_reader_if.master    port
);
  rd_state_t     r_state, w_nxt;
  logic          r_rd_q, r_up_q, r_cval;
  logic [15:0]   r_cache, w_pf_q;
  logic [AW-1:0] r_cwa, w_wa, w_pf_wa;
  logic          w_edge, w_hit, w_pf_hit, w_issue, w_pf_issue, w_promote, w_abort;
  logic          w_fill, w_tmo_hit, w_done, w_idle, w_tmo, w_unused;
  assign w_wa     = ioctl_addr[AW:1] - AW'(BASE_WORD);
  assign w_edge   = ioctl_rd & ~r_rd_q;
  assign w_hit    = r_cval & (r_cwa == w_wa);
  assign w_unused = &{1'b0, ioctl_addr, w_idle};
  assign port.port_ds = 2'b11;
  assign port.port_we = 1'b0;
  toggle_port_client #(.AW(AW), .TIMEOUT_CYC(TIMEOUT_CYC)) u_client (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_issue (w_issue | w_pf_issue),
    .i_abort (w_abort),
    .i_addr  (w_issue ? w_wa : r_cwa + AW'(1)),
    .i_ack   (port.port_ack),
    .o_req   (port.port_req),
    .o_a     (port.port_a),
    .o_done  (w_done),
    .o_idle  (w_idle),
    .o_tmo   (w_tmo)
  );
`ifdef IOCTL_READ_PREFETCH_EN
  logic          r_pf_go, r_pf_busy, r_pf_val;
  logic [15:0]   r_pf;
  logic [AW-1:0] r_pf_wa;
  assign w_pf_hit   = r_pf_val & (r_pf_wa == w_wa);
  assign w_pf_issue = r_pf_go & (r_state == IDLE) & ~w_edge & w_idle & ioctl_upload;
  assign w_pf_q     = r_pf;
  assign w_pf_wa    = r_pf_wa;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pf_go   <= 1'b0;
      r_pf_busy <= 1'b0;
      r_pf_val  <= 1'b0;
      r_pf      <= '0;
      r_pf_wa   <= '0;
    end else begin
      r_pf_go <= (r_state == SERVE) & ioctl_addr[0];
      if (w_done & r_pf_busy) begin
        r_pf      <= port.port_q;
        r_pf_val  <= 1'b1;
        r_pf_busy <= 1'b0;
      end
      if (w_pf_issue) begin
        r_pf_wa   <= r_cwa + AW'(1);
        r_pf_busy <= 1'b1;
        r_pf_val  <= 1'b0;
      end
      if (w_promote) r_pf_val <= 1'b0;
      if (w_issue | w_abort) begin
        r_pf_busy <= 1'b0;
        r_pf_val  <= 1'b0;
      end
    end
  end
`else
  assign w_pf_hit   = 1'b0;
  assign w_pf_issue = 1'b0;
  assign w_pf_q     = '0;
  assign w_pf_wa    = '0;
`endif
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt     = r_state;
    w_issue   = 1'b0;
    w_promote = 1'b0;
    w_abort   = 1'b0;
    w_fill    = 1'b0;
    w_tmo_hit = 1'b0;
    if (!ioctl_upload) begin
      w_nxt   = IDLE;
      w_abort = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_edge) begin
          w_nxt     = (w_hit | w_pf_hit) ? SERVE : WAIT;
          w_issue   = ~(w_hit | w_pf_hit);
          w_promote = ~w_hit & w_pf_hit;
        end
        WAIT: begin
          w_fill    = w_done;
          w_tmo_hit = ~w_done & w_tmo;
          w_abort   = w_tmo_hit;
          w_nxt     = w_done ? SERVE : w_tmo_hit ? IDLE : WAIT;
        end
        default: w_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_q    <= 1'b0;
      r_up_q    <= 1'b0;
      r_cval    <= 1'b0;
      r_cache   <= '0;
      r_cwa     <= '0;
      ioctl_din <= '0;
      rd_ready  <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      r_rd_q <= ioctl_rd;
      r_up_q <= ioctl_upload;
      if (w_edge) rd_ready <= 1'b0;
      if (ioctl_upload & ~r_up_q) rd_err <= 1'b0;
      if (w_fill | w_promote) begin
        r_cache <= w_fill ? port.port_q : w_pf_q;
        r_cwa   <= w_fill ? port.port_a : w_pf_wa;
        r_cval  <= 1'b1;
      end
      if ((r_state == SERVE) & ioctl_upload) begin
        ioctl_din <= byte_sel(r_cache, ioctl_addr[0]);
        rd_ready  <= 1'b1;
      end
      if (w_tmo_hit) begin
        ioctl_din <= 8'hFF;
        rd_ready  <= 1'b1;
        rd_err    <= 1'b1;
      end
      if (w_tmo_hit | ~ioctl_upload) r_cval <= 1'b0;
    end
  end
endmodule
